// File: rtl/fpga_run_pkg.sv
// Shared types and constants for the run sequencer: FSM states, step counter
// width and the out-channel element type.
package fpga_run_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } seq_state_t;

   localparam int STEP_CNT_W = 32;
   localparam int MEM_ELEM_W = 12;

   typedef logic [MEM_ELEM_W-1:0] mem_elem_t;

endpackage

// File: rtl/fpga_run_sequencer_out_checker.sv
// Expected-value table plus out-channel comparator: wrapping position, sticky
// mismatch flag and saturating write count. SEQ_TRACE_EN adds mismatch prints.
module out_checker import fpga_run_pkg::*; #(
   parameter int MemoryElementWidth = MEM_ELEM_W,
   parameter int NOut = 2,
   localparam int AddrWidth = (NOut > 1) ? $clog2(NOut) : 1,
   localparam int CountWidth = $clog2(NOut + 2)
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_clear,
   input  logic                          i_active,
   input  logic                          i_cfg_en,
   input  logic [AddrWidth-1:0]          i_cfg_addr,
   input  logic [MemoryElementWidth-1:0] i_cfg_data,
   input  logic                          i_out_valid,
   input  logic [MemoryElementWidth-1:0] i_out_data,
   output logic                          o_mismatch,
   output logic [CountWidth-1:0]         o_out_count
);

   logic [MemoryElementWidth-1:0] r_expected [NOut];
   logic [AddrWidth-1:0]          r_out_pos;
   logic [CountWidth-1:0]         r_out_count;
   logic                          r_mismatch;
   logic [MemoryElementWidth-1:0] w_expected;
   logic                          w_hit;

   // The table survives reset so a board harness loads it once for many runs.
   always_ff @(posedge i_clock) begin
      if (i_cfg_en) begin
         r_expected[i_cfg_addr] <= i_cfg_data;
      end
   end

   assign w_expected = r_expected[r_out_pos];
   assign w_hit      = i_active && i_out_valid;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_out_pos   <= '0;
         r_out_count <= '0;
         r_mismatch  <= 1'b0;
      end else if (i_clear) begin
         r_out_pos   <= '0;
         r_out_count <= '0;
         r_mismatch  <= 1'b0;
      end else if (w_hit) begin
         if (i_out_data != w_expected) begin
            r_mismatch <= 1'b1;
         end
         r_out_pos <= (r_out_pos == AddrWidth'(NOut - 1)) ? '0 : r_out_pos + 1'b1;
         // Saturating one past NOut is enough to tell "too many writes" apart.
         if (r_out_count != CountWidth'(NOut + 1)) begin
            r_out_count <= r_out_count + 1'b1;
         end
      end
   end

   assign o_mismatch  = r_mismatch;
   assign o_out_count = r_out_count;

`ifdef SEQ_TRACE_EN
   always @(posedge i_clock) begin
      if (!i_reset && w_hit && (i_out_data != w_expected)) begin
         $display("[out_checker] mismatch at out_pos %0d: expected %0d actual %0d",
                  r_out_pos, w_expected, i_out_data);
      end
   end
`endif

endmodule

// File: rtl/fpga_run_sequencer.sv
// Single-step sequencer for one program core: strobes steps, enforces a step
// budget and grades out-channel writes. SEQ_TRACE_EN adds per-step prints.
module fpga_run_sequencer import fpga_run_pkg::*; #(
   parameter int MemoryElementWidth = MEM_ELEM_W,
   parameter int NOut = 2,
   parameter int NInstructions = 12,
   parameter int MaxSteps = 64,
   parameter int IpWidth = 16,
   localparam int AddrWidth = (NOut > 1) ? $clog2(NOut) : 1,
   localparam int CountWidth = $clog2(NOut + 2)
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_run,
   input  logic                          i_cfg_we,
   input  logic [AddrWidth-1:0]          i_cfg_addr,
   input  logic [MemoryElementWidth-1:0] i_cfg_data,
   output logic                          o_step,
   input  logic                          i_step_done,
   input  logic [IpWidth-1:0]            i_ip,
   input  logic                          i_out_valid,
   input  logic [MemoryElementWidth-1:0] i_out_data,
   output logic                          o_finished,
   output logic                          o_success,
   output logic                          o_timeout,
   output logic [STEP_CNT_W-1:0]         o_steps
);

   seq_state_t              r_state;
   logic                    r_step;
   logic                    r_finished;
   logic                    r_success;
   logic                    r_timeout;
   logic [STEP_CNT_W-1:0]   r_steps;

   logic                    w_idle_like;
   logic                    w_start;
   logic                    w_active;
   logic                    w_cfg_en;
   logic [STEP_CNT_W-1:0]   w_steps_inc;
   logic                    w_ended;
   logic                    w_budget_hit;
   logic                    w_mismatch;
   logic [CountWidth-1:0]   w_out_count;

   assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_start      = w_idle_like && i_run;
   assign w_active     = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_CHECK);
   assign w_cfg_en     = w_idle_like && i_cfg_we;
   assign w_steps_inc  = r_steps + 32'd1;
   assign w_ended      = i_ip >= IpWidth'(NInstructions);
   assign w_budget_hit = w_steps_inc == STEP_CNT_W'(MaxSteps);

   out_checker #(
      .MemoryElementWidth (MemoryElementWidth),
      .NOut               (NOut)
   ) u_out_checker (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_clear     (w_start),
      .i_active    (w_active),
      .i_cfg_en    (w_cfg_en),
      .i_cfg_addr  (i_cfg_addr),
      .i_cfg_data  (i_cfg_data),
      .i_out_valid (i_out_valid),
      .i_out_data  (i_out_data),
      .o_mismatch  (w_mismatch),
      .o_out_count (w_out_count)
   );

   // r_step is raised on every transition into ISSUE so it is high exactly
   // while the FSM sits in ISSUE.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_step     <= 1'b0;
         r_finished <= 1'b0;
         r_success  <= 1'b0;
         r_timeout  <= 1'b0;
         r_steps    <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_run) begin
                  r_steps    <= '0;
                  r_finished <= 1'b0;
                  r_success  <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_step     <= 1'b1;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_step  <= 1'b0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_step_done) begin
                  r_steps <= w_steps_inc;
                  // Program end wins over budget exhaustion on the same step.
                  if (w_ended) begin
                     r_state <= ST_CHECK;
                  end else if (w_budget_hit) begin
                     r_timeout  <= 1'b1;
                     r_finished <= 1'b1;
                     r_success  <= 1'b0;
                     r_state    <= ST_DONE;
                  end else begin
                     r_step  <= 1'b1;
                     r_state <= ST_ISSUE;
                  end
               end
            end
            ST_CHECK: begin
               r_success  <= !w_mismatch && (w_out_count == CountWidth'(NOut));
               r_finished <= 1'b1;
               r_state    <= ST_DONE;
            end
            default: begin
               r_step  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_step     = r_step;
   assign o_finished = r_finished;
   assign o_success  = r_success;
   assign o_timeout  = r_timeout;
   assign o_steps    = r_steps;

`ifdef SEQ_TRACE_EN
   always @(posedge i_clock) begin
      if (!i_reset && (r_state == ST_WAIT) && i_step_done) begin
         $display("[fpga_run_sequencer] step %0d ip %0d", w_steps_inc, i_ip);
      end
   end
`endif

endmodule

// File: tb/tb_fpga_run_sequencer.sv
// Directed bench for fpga_run_sequencer: table of program scenarios plus
// hand-written timeout, mid-run reset and ignored run/cfg sequences.
module tb_fpga_run_sequencer;

   typedef struct {
      logic [11:0] d0;
      bit          e0;
      logic [11:0] d1;
      bit          e1;
      logic [11:0] d2;
      bit          e2;
      bit          same;
      bit          exp_success;
   } scen_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_a, run_b;
   logic        cfg_we;
   logic [0:0]  cfg_addr;
   logic [11:0] cfg_data;
   logic        step_done;
   logic [15:0] ip;
   logic        out_valid;
   logic [11:0] out_data;

   logic        step_a, fin_a, suc_a, to_a;
   logic [31:0] steps_a;
   logic        step_b, fin_b, suc_b, to_b;
   logic [31:0] steps_b;

   bit          sel = 1'b0;
   logic        w_step_mon;

   int          n_cmp = 0;
   int          n_err = 0;

   scen_t       scen [6];
   logic [15:0] prog_ip [10];

   always #5 clk = ~clk;

   assign w_step_mon = sel ? step_b : step_a;

   fpga_run_sequencer dut_a (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_run       (run_a),
      .i_cfg_we    (cfg_we),
      .i_cfg_addr  (cfg_addr),
      .i_cfg_data  (cfg_data),
      .o_step      (step_a),
      .i_step_done (step_done),
      .i_ip        (ip),
      .i_out_valid (out_valid),
      .i_out_data  (out_data),
      .o_finished  (fin_a),
      .o_success   (suc_a),
      .o_timeout   (to_a),
      .o_steps     (steps_a)
   );

   fpga_run_sequencer #(.MaxSteps(4)) dut_b (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_run       (run_b),
      .i_cfg_we    (cfg_we),
      .i_cfg_addr  (cfg_addr),
      .i_cfg_data  (cfg_data),
      .o_step      (step_b),
      .i_step_done (step_done),
      .i_ip        (ip),
      .i_out_valid (out_valid),
      .i_out_data  (out_data),
      .o_finished  (fin_b),
      .o_success   (suc_b),
      .o_timeout   (to_b),
      .o_steps     (steps_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One core instruction: wait for the strobe, optionally write out during
   // ISSUE, then answer in WAIT with step_done (plus an optional same-cycle write).
   task automatic core_step(input logic [15:0] ip_v, input bit pre_en, input logic [11:0] pre_d,
                            input bit same_en, input logic [11:0] same_d, input bit in_wait);
      int n = 0;
      if (!in_wait) begin
         while (w_step_mon !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
         end
         check("step_strobe", {31'd0, w_step_mon}, 32'd1);
         out_valid = pre_en;
         out_data  = pre_d;
         @(negedge clk);
      end
      step_done = 1'b1;
      ip        = ip_v;
      out_valid = same_en;
      out_data  = same_d;
      @(negedge clk);
      step_done = 1'b0;
      out_valid = 1'b0;
   endtask

   task automatic run_steps(input scen_t s, input int from, input int to, input bit in_wait);
      for (int k = from; k <= to; k++) begin
         bit          pe, se;
         logic [11:0] pd, sd;
         pe = 1'b0; se = 1'b0; pd = '0; sd = '0;
         if (s.same) begin
            if (k == 5 && s.e0) begin se = 1'b1; sd = s.d0; end
            if (k == 7 && s.e1) begin se = 1'b1; sd = s.d1; end
            if (k == 9 && s.e2) begin se = 1'b1; sd = s.d2; end
         end else begin
            if (k == 6 && s.e0) begin pe = 1'b1; pd = s.d0; end
            if (k == 8 && s.e1) begin pe = 1'b1; pd = s.d1; end
            if (k == 10 && s.e2) begin pe = 1'b1; pd = s.d2; end
         end
         core_step(prog_ip[k-1], pe, pd, se, sd, (k == from) && in_wait);
      end
   endtask

   task automatic start_run_a();
      run_a = 1'b1;
      @(negedge clk);
      run_a = 1'b0;
      check("start_finished", {31'd0, fin_a}, 32'd0);
      check("start_steps", steps_a, 32'd0);
   endtask

   task automatic wait_fin_a();
      int n = 0;
      while (fin_a !== 1'b1 && n < 6) begin
         @(negedge clk);
         n++;
      end
      check("finished", {31'd0, fin_a}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      scen[0] = '{12'd111, 1'b1, 12'd333, 1'b1, 12'd0,   1'b0, 1'b0, 1'b1};
      scen[1] = '{12'd111, 1'b1, 12'd334, 1'b1, 12'd0,   1'b0, 1'b0, 1'b0};
      scen[2] = '{12'd111, 1'b1, 12'd0,   1'b0, 12'd0,   1'b0, 1'b0, 1'b0};
      scen[3] = '{12'd111, 1'b1, 12'd333, 1'b1, 12'd111, 1'b1, 1'b0, 1'b0};
      scen[4] = '{12'd111, 1'b1, 12'd333, 1'b1, 12'd0,   1'b0, 1'b1, 1'b1};
      scen[5] = '{12'd333, 1'b1, 12'd111, 1'b1, 12'd0,   1'b0, 1'b0, 1'b0};
      prog_ip = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};

      rst = 1'b1; run_a = 1'b0; run_b = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
      cfg_data = '0; step_done = 1'b0; ip = '0; out_valid = 1'b0; out_data = '0;
      repeat (2) @(negedge clk);
      check("reset_step", {31'd0, step_a}, 32'd0);
      check("reset_finished", {31'd0, fin_a}, 32'd0);
      check("reset_success", {31'd0, suc_a}, 32'd0);
      check("reset_timeout", {31'd0, to_a}, 32'd0);
      check("reset_steps", steps_a, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      cfg_we = 1'b1; cfg_addr = 1'b0; cfg_data = 12'd111;
      @(negedge clk);
      cfg_addr = 1'b1; cfg_data = 12'd333;
      @(negedge clk);
      cfg_we = 1'b0;

      for (int i = 0; i < 6; i++) begin
         start_run_a();
         run_steps(scen[i], 1, 10, 1'b0);
         wait_fin_a();
         check("scen_success", {31'd0, suc_a}, {31'd0, scen[i].exp_success});
         check("scen_timeout", {31'd0, to_a}, 32'd0);
         check("scen_steps", steps_a, 32'd10);
         @(negedge clk);
         check("done_no_step", {31'd0, step_a}, 32'd0);
         $display("scenario %0d: finished=%0d success=%0d timeout=%0d steps=%0d",
                  i, fin_a, suc_a, to_a, steps_a);
      end

      // Step budget of 4 on the second instance, ip never leaves the program.
      sel = 1'b1;
      run_b = 1'b1;
      @(negedge clk);
      run_b = 1'b0;
      for (int k = 0; k < 3; k++) core_step(16'd3, 1'b0, '0, 1'b0, '0, 1'b0);
      check("budget_minus1_timeout", {31'd0, to_b}, 32'd0);
      check("budget_minus1_finished", {31'd0, fin_b}, 32'd0);
      core_step(16'd3, 1'b0, '0, 1'b0, '0, 1'b0);
      check("timeout_flag", {31'd0, to_b}, 32'd1);
      check("timeout_finished", {31'd0, fin_b}, 32'd1);
      check("timeout_success", {31'd0, suc_b}, 32'd0);
      check("timeout_steps", steps_b, 32'd4);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("timeout_no_step", {31'd0, step_b}, 32'd0);
      end
      $display("timeout run: finished=%0d success=%0d timeout=%0d steps=%0d", fin_b, suc_b, to_b, steps_b);
      sel = 1'b0;

      // Asynchronous reset while waiting on the fourth instruction.
      start_run_a();
      run_steps(scen[0], 1, 3, 1'b0);
      @(negedge clk);
      check("pre_reset_steps", steps_a, 32'd3);
      rst = 1'b1;
      #1;
      check("async_reset_steps", steps_a, 32'd0);
      check("async_reset_step", {31'd0, step_a}, 32'd0);
      check("async_reset_finished", {31'd0, fin_a}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step_done = 1'b1; ip = 16'd12;
      @(negedge clk);
      step_done = 1'b0;
      repeat (3) @(negedge clk);
      check("late_done_steps", steps_a, 32'd0);
      check("late_done_finished", {31'd0, fin_a}, 32'd0);
      check("late_done_step", {31'd0, step_a}, 32'd0);
      start_run_a();
      run_steps(scen[0], 1, 10, 1'b0);
      wait_fin_a();
      check("after_reset_success", {31'd0, suc_a}, 32'd1);
      check("after_reset_steps", steps_a, 32'd10);
      $display("post-reset run: finished=%0d success=%0d steps=%0d", fin_a, suc_a, steps_a);

      // run and cfg_we while in WAIT are ignored; outs land with step_done.
      start_run_a();
      run_steps(scen[4], 1, 2, 1'b0);
      @(negedge clk);
      run_a = 1'b1; cfg_we = 1'b1; cfg_addr = 1'b0; cfg_data = 12'd999;
      @(negedge clk);
      run_a = 1'b0; cfg_we = 1'b0;
      check("busy_run_steps", steps_a, 32'd2);
      check("busy_run_step", {31'd0, step_a}, 32'd0);
      run_steps(scen[4], 3, 10, 1'b1);
      wait_fin_a();
      check("busy_cfg_success", {31'd0, suc_a}, 32'd1);
      check("busy_cfg_steps", steps_a, 32'd10);
      $display("busy run/cfg: finished=%0d success=%0d steps=%0d", fin_a, suc_a, steps_a);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
